// File: rtl/serializer_pkg.sv
// Shared types for the word-to-byte serializer: FSM states, the stored word
// layout and the byte/status widths.
package serializer_pkg;

    localparam int BYTE_W   = 8;
    localparam int STATUS_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_HI = 2'd1,
        SEND_LO = 2'd2
    } state_t;

    typedef struct packed {
        logic [BYTE_W-1:0]   high;
        logic [BYTE_W-1:0]   low;
        logic [STATUS_W-1:0] status;
    } word_t;

endpackage

// File: rtl/word_byte_serializer_if.sv
// Word input strobe plus byte output stream of the serializer.
// slave is the serializer's view, master is the upstream/downstream side.
interface word_byte_serializer_if;
    import serializer_pkg::*;

    logic                in_valid;
    logic [BYTE_W-1:0]   in_data_high;
    logic [BYTE_W-1:0]   in_data_low;
    logic [STATUS_W-1:0] in_status;

    logic [BYTE_W-1:0]   out_byte;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [STATUS_W-1:0] out_status;

    modport master (
        output in_valid, in_data_high, in_data_low, in_status, out_ready,
        input  out_byte, out_valid, out_last, out_status
    );

    modport slave (
        input  in_valid, in_data_high, in_data_low, in_status, out_ready,
        output out_byte, out_valid, out_last, out_status
    );
endinterface

// File: rtl/word_fifo.sv
// Synchronous DEPTH x word FIFO with wrap-bit pointers and a level output.
// Zero-latency read of the head word; push while full is legal when a pop happens in the same cycle.
// No internal backpressure: caller gates push/pop with full/empty.
module word_fifo
    import serializer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  word_t                  wdata,
    output word_t                  rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    word_t         mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Extra wrap bit lets the pointer difference span 0..DEPTH.
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/word_byte_serializer.sv
// Buffers strobed 16-bit words + status and streams them as bytes, high byte first, with frame marking and drop stats.
// First byte valid 2 edges after the strobe; 2 cycles per word sustained.
// out_ready stalls the stream with outputs held; upstream cannot be stalled, so a full FIFO drops and counts words.
module word_byte_serializer
    import serializer_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int FRAME_WORDS = 8,
    parameter int CNT_W       = 8
) (
    input  logic                   sys_clk,
    input  logic                   sys_reset,
    word_byte_serializer_if.slave  bus,
    input  logic                   clear_stats,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       drop_count,
    output logic                   overflow
);
    localparam int FC_W = $clog2(FRAME_WORDS) + 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_WORDS - 1);

    state_t              state_q;
    state_t              state_d;
    word_t               head;
    word_t               in_word;
    logic                full;
    logic                empty;
    logic                pop;
    logic                push;
    logic                drop;
    logic                hs;
    logic                load_hi;
    logic                load_lo;
    logic                frame_end;
    logic [BYTE_W-1:0]   byte_q;
    logic [BYTE_W-1:0]   low_q;
    logic [STATUS_W-1:0] status_q;
    logic                last_q;
    logic [FC_W-1:0]     frame_cnt_q;

    assign in_word   = '{high: bus.in_data_high, low: bus.in_data_low, status: bus.in_status};
    assign hs        = bus.out_valid && bus.out_ready;
    assign frame_end = (state_q == SEND_LO) && hs;
    assign push      = bus.in_valid && (!full || pop);
    assign drop      = bus.in_valid && full && !pop;

    word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_word),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load_hi = 1'b0;
        load_lo = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    load_hi = 1'b1;
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                if (hs) begin
                    load_lo = 1'b1;
                    state_d = SEND_LO;
                end
            end
            SEND_LO: begin
                // Chain straight into the next word so the stream has no bubble.
                if (hs) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        load_hi = 1'b1;
                        state_d = SEND_HI;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            byte_q      <= '0;
            low_q       <= '0;
            status_q    <= '0;
            last_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (load_hi) begin
                byte_q   <= head.high;
                low_q    <= head.low;
                status_q <= head.status;
                last_q   <= 1'b0;
            end else if (load_lo) begin
                byte_q <= low_q;
                last_q <= (frame_cnt_q == FC_LAST);
            end else if (frame_end) begin
                last_q <= 1'b0;
            end
            if (frame_end) begin
                frame_cnt_q <= (frame_cnt_q == FC_LAST) ? '0 : frame_cnt_q + FC_W'(1);
            end
        end
    end

    // A clear wins over a drop in the same cycle; that drop goes unrecorded.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear_stats) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
        end
    end

    assign bus.out_valid  = (state_q != IDLE);
    assign bus.out_byte   = byte_q;
    assign bus.out_status = status_q;
    assign bus.out_last   = last_q;
endmodule

// File: tb/tb_word_byte_serializer.sv
// Bench for word_byte_serializer: directed scenarios plus random traffic,
// each cycle checked against a word-queue reference model.
module tb_word_byte_serializer;
    import serializer_pkg::*;

    localparam int DEPTH = 4;
    localparam int FW    = 8;
    localparam int CNT_W = 8;

    logic             sys_clk     = 1'b0;
    logic             sys_reset   = 1'b1;
    logic             clear_stats = 1'b0;
    logic [2:0]       fifo_level;
    logic [CNT_W-1:0] drop_count;
    logic             overflow;

    word_byte_serializer_if bus ();

    word_byte_serializer #(.DEPTH(DEPTH), .FRAME_WORDS(FW), .CNT_W(CNT_W)) dut (
        .sys_clk     (sys_clk),
        .sys_reset   (sys_reset),
        .bus         (bus.slave),
        .clear_stats (clear_stats),
        .fifo_level  (fifo_level),
        .drop_count  (drop_count),
        .overflow    (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: words waiting, the word on the wire and which half of it is showing.
    word_t m_q[$];
    word_t m_cur;
    bit    m_busy  = 0;
    bit    m_lo    = 0;
    int    m_frame = 0;
    int    m_drops = 0;
    bit    m_ovf   = 0;

    always @(posedge sys_clk or negedge sys_reset) begin
        bit    hs, take, full;
        word_t w;
        word_t nw;
        if (!sys_reset) begin
            m_q.delete();
            m_busy = 0; m_lo = 0; m_frame = 0; m_drops = 0; m_ovf = 0;
        end else begin
            hs   = m_busy && bus.out_ready;
            take = (m_q.size() > 0) && (!m_busy || (hs && m_lo));
            full = (m_q.size() == DEPTH);
            nw   = '{high: bus.in_data_high, low: bus.in_data_low, status: bus.in_status};
            w    = '0;
            if (take) w = m_q.pop_front();
            if (bus.in_valid) begin
                if (!full || take) m_q.push_back(nw);
                else if (!clear_stats) begin
                    if (m_drops < 255) m_drops++;
                    m_ovf = 1;
                end
            end
            if (clear_stats) begin m_drops = 0; m_ovf = 0; end
            if (hs && m_lo) m_frame = (m_frame + 1) % FW;
            if (take) begin m_cur = w; m_busy = 1; m_lo = 0; end
            else if (hs && !m_lo) m_lo = 1;
            else if (hs && m_lo) m_busy = 0;
        end
    end

    task automatic compare_all();
        check("valid", bus.out_valid, m_busy);
        if (m_busy) begin
            check("byte",   bus.out_byte, m_lo ? m_cur.low : m_cur.high);
            check("status", bus.out_status, m_cur.status);
        end
        check("last",  bus.out_last, m_busy && m_lo && (m_frame == FW - 1));
        check("level", fifo_level, m_q.size());
        check("drops", drop_count, m_drops);
        check("ovf",   overflow, m_ovf);
    endtask

    logic [7:0] byte_log[$];
    int         last_hits = 0;

    // Called just after a falling edge: drive, log what will hand off, then compare after the next edge.
    task automatic cycle(input bit v, input word_t w, input bit rdy, input bit clr);
        bus.in_valid     = v;
        bus.in_data_high = w.high;
        bus.in_data_low  = w.low;
        bus.in_status    = w.status;
        bus.out_ready    = rdy;
        clear_stats      = clr;
        if (bus.out_valid && rdy) begin
            byte_log.push_back(bus.out_byte);
            if (bus.out_last) last_hits++;
        end
        @(negedge sys_clk);
        compare_all();
    endtask

    task automatic do_reset();
        bus.in_valid = 0;
        clear_stats  = 0;
        sys_reset    = 0;
        #1;
        check("rst_valid",  bus.out_valid, 0);
        check("rst_byte",   bus.out_byte, 0);
        check("rst_status", bus.out_status, 0);
        check("rst_last",   bus.out_last, 0);
        check("rst_level",  fifo_level, 0);
        check("rst_drops",  drop_count, 0);
        check("rst_ovf",    overflow, 0);
        @(negedge sys_clk);
        sys_reset = 1;
    endtask

    function automatic word_t rand_word();
        logic [17:0] r;
        r = 18'($urandom);
        return r;
    endfunction

    word_t none = '0;
    word_t ow[7];

    initial begin
        bus.in_valid = 0; bus.in_data_high = 0; bus.in_data_low = 0;
        bus.in_status = 0; bus.out_ready = 0;
        #1;
        @(negedge sys_clk);
        do_reset();

        // Single word, two-edge latency, bytes back to back.
        cycle(1, '{high: 8'hA5, low: 8'h3C, status: 2'b10}, 1, 0);
        check("lat_e0_valid", bus.out_valid, 0);
        cycle(0, none, 1, 0);
        check("single_hi",   bus.out_byte, 8'hA5);
        check("single_stat", bus.out_status, 2'b10);
        cycle(0, none, 1, 0);
        check("single_lo",   bus.out_byte, 8'h3C);
        check("single_last", bus.out_last, 0);
        cycle(0, none, 1, 0);
        check("single_done", bus.out_valid, 0);

        // Stall for 5 cycles on the low byte.
        cycle(1, '{high: 8'h11, low: 8'h3C, status: 2'b01}, 1, 0);
        cycle(0, none, 1, 0);
        cycle(0, none, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, none, 0, 0);
            check("bp_byte",  bus.out_byte, 8'h3C);
            check("bp_valid", bus.out_valid, 1);
        end
        cycle(0, none, 1, 0);
        check("bp_done", bus.out_valid, 0);

        // Overflow: 7 strobes into a stalled 4-deep FIFO.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            ow[i] = rand_word();
            cycle(1, ow[i], 0, 0);
        end
        check("ovf_drops", drop_count, 2);
        check("ovf_flag",  overflow, 1);
        check("ovf_level", fifo_level, 4);
        byte_log.delete();
        for (int i = 0; i < 12; i++) cycle(0, none, 1, 0);
        check("ovf_nbytes", byte_log.size(), 10);
        for (int i = 0; i < 5; i++) begin
            if (byte_log.size() >= 2 * i + 2) begin
                check("ovf_drain_hi", byte_log[2*i],   ow[i].high);
                check("ovf_drain_lo", byte_log[2*i+1], ow[i].low);
            end
        end

        // Two frames of 8 words at full rate.
        do_reset();
        last_hits = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1, rand_word(), 1, 0);
            cycle(0, none, 1, 0);
        end
        for (int i = 0; i < 4; i++) cycle(0, none, 1, 0);
        check("frame_last_hits", last_hits, 2);

        // Clear in the same cycle as a drop.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, rand_word(), 0, 0);
        check("clr_full_level", fifo_level, 4);
        cycle(1, rand_word(), 0, 1);
        check("clr_drops", drop_count, 0);
        check("clr_ovf",   overflow, 0);
        cycle(1, rand_word(), 0, 0);
        check("clr_next_drops", drop_count, 1);
        check("clr_next_ovf",   overflow, 1);

        // Reset while on the low byte with 3 words queued.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, rand_word(), 0, 0);
        cycle(0, none, 1, 0);
        check("mid_level", fifo_level, 3);
        check("mid_valid", bus.out_valid, 1);
        bus.out_ready = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(0, none, 1, 0);
            check("stale_valid", bus.out_valid, 0);
        end

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 45, rand_word(),
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/word_byte_serializer.md
# word_byte_serializer

Downstream consumer of the partial-test system's split 16-bit result. Captures one word (high byte, low byte, 2-bit status) per `in_valid` strobe into a small FIFO and emits it as a byte stream with a valid/ready handshake, high byte first. It marks frame boundaries and counts words dropped on overflow. The upstream stage has no backpressure; this block absorbs bursts and reports losses.

## Interface
- `DEPTH`, 4: FIFO depth in words; power of two, at least 2.
- `FRAME_WORDS`, 8: words per frame; `out_last` marks the last byte of each frame; at least 1.
- `CNT_W`, 8: width of the drop counter.

- `sys_clk` in 1: single clock; all logic on its rising edge.
- `sys_reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: one-cycle word strobe, driven from upstream `system_ready`.
- `in_data_high` in 8: upstream `output_data_high`.
- `in_data_low` in 8: upstream `output_data_low`.
- `in_status` in 2: upstream `status_low`.
- `out_byte` out 8: current output byte.
- `out_valid` out 1: `out_byte` is valid.
- `out_ready` in 1: downstream accepts the byte.
- `out_last` out 1: current byte is the low byte of word `FRAME_WORDS`-1 of the frame.
- `out_status` out 2: status of the word the current byte belongs to.
- `fifo_level` out clog2(DEPTH)+1: words stored, excluding the word being sent.
- `drop_count` out CNT_W: saturating count of dropped words.
- `overflow` out 1: sticky; set on any drop.
- `clear_stats` in 1: synchronous clear of `drop_count` and `overflow`.

## Operation
- **Push.** On `in_valid`, write {high, low, status} to the FIFO if not full, or if full and a pop occurs in the same cycle; in that case `fifo_level` is unchanged.
- **Drop.** If the FIFO is full and there is no pop, the word is discarded, `drop_count` increments (saturating at all-ones) and `overflow` is set.
- **FSM states:** IDLE, SEND_HI, SEND_LO.
  - IDLE: if the FIFO is non-empty, pop, load the high byte, go to SEND_HI.
  - SEND_HI: on `out_valid && out_ready`, load the low byte, go to SEND_LO.
  - SEND_LO: on handshake, if the FIFO is non-empty, pop and load the next high byte (SEND_HI, no bubble); else go to IDLE.
- **Output stability.** `out_valid`=1 exactly in SEND_HI/SEND_LO. `out_byte`, `out_status` and `out_last` are registered and stay stable while `out_valid && !out_ready`.
- **Frame counter.** Width clog2(FRAME_WORDS)+1. Increments on each low-byte handshake. `out_last`=1 in SEND_LO when the counter equals FRAME_WORDS-1. The counter wraps to 0 after that handshake.
- **`clear_stats`.** Has priority over a same-cycle drop; that drop is not counted and does not set `overflow`.
- **Reset.** Asserting `sys_reset` mid-transfer aborts the current word and empties the FIFO. Reset values:
  - FSM = IDLE
  - `out_valid` = 0, `out_byte` = 0, `out_status` = 0, `out_last` = 0
  - `fifo_level` = 0, `drop_count` = 0, `overflow` = 0, frame counter = 0

## Timing
- A word strobed at edge E0 sets `out_valid` with its high byte after edge E1 (FIFO empty, FSM IDLE). Latency is 2 edges from `in_valid` sampling to first byte.
- Sustained throughput is 2 cycles per word with `out_ready` held high. Upstream strobes faster than this for more than DEPTH+1 words cause drops.
- A pop happens only on the IDLE→SEND_HI transition or on a SEND_LO handshake with a non-empty FIFO.
- `fifo_level`, `drop_count` and `overflow` update on the edge after the event.
- Reset release is asynchronous assert, synchronous deassert at the top level; the block needs no extra deassert latency.

## Structure
- **Shared package `serializer_pkg`:**
  - state enum (IDLE, SEND_HI, SEND_LO)
  - word struct {high[7:0], low[7:0], status[1:0]}
  - width localparams (`BYTE_W`=8, `STATUS_W`=2)
- **Sub-module `word_fifo`:**
  - synchronous, DEPTH x 18-bit
  - registered pointers, one extra wrap bit
  - full/empty/level outputs
  - push-on-full-with-pop allowed
- The top contains the FSM, output registers, frame counter and stats.

## Test plan
- Single word 0xA5/0x3C, status 2'b10, `out_ready`=1: bytes 0xA5 then 0x3C on consecutive cycles, `out_status`=2'b10, first `out_valid` 2 edges after the strobe, `out_last`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles mid-word. `out_byte` stays at 0x3C and `out_valid` stays 1, with no duplicate or lost byte.
- Overflow: `out_ready`=0, strobe 7 words with DEPTH=4. Required: 5 words retained (4 stored plus 1 loaded), `drop_count`=2, `overflow`=1, `fifo_level`=4. Drain: the bytes of words 0–4 come out in order.
- Frame: 16 words with FRAME_WORDS=8 and continuous `out_ready`. `out_last` is high only on the low bytes of words 7 and 15.
- `clear_stats` in the same cycle as a drop: `drop_count`=0 and `overflow`=0 afterwards. The next drop gives `drop_count`=1.
- Reset asserted during SEND_LO with 3 words queued: outputs go to their reset values immediately. After release, no stale bytes are emitted.
